seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Sequential display stage downstream of the lab combinational decode blocks. It consumes a 16-bit hex word (four nibbles) plus per-digit blank and decimal-point flags, and time-multiplexes them onto a 4-digit common-anode seven-segment display. New words are double-buffered and committed only at frame boundaries, so the display never tears. A one-cycle acknowledge pulse marks each commit.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is driven; legal range 4..2^20.
GUARD, 2, cycles at the start of each digit slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
load_i  input  1  capture hex_i/blank_i/dp_i into the pending buffer this cycle
hex_i  input  16  digit n = hex_i[4n+3:4n]; digit 0 is rightmost
blank_i  input  4  bit n=1 blanks digit n (segments and dp off)
dp_i  input  4  bit n=1 lights the decimal point of digit n
seg_o  output  7  active-low segments {g,f,e,d,c,b,a}
dp_o  output  1  active-low decimal point
an_o  output  4  active-low anodes; bit n drives digit n
ack_o  output  1  one-cycle pulse: pending word committed to the display

Behaviour:
- Reset (async assert, sync-safe release): prescaler=0, digit=0, display word=0, display blank=4'b1111, display dp=0, pending_valid=0; an_o=4'b1111, seg_o=7'h7F, dp_o=1, ack_o=0. Reset mid-frame discards pending and displayed data.
- Prescaler p counts 0..REFRESH_DIV-1 and wraps. tick = (p==REFRESH_DIV-1). On tick: digit <= digit+1 (2-bit, wraps 3->0).
- Frame boundary: a tick while digit==3 (digit goes 3->0).
- Pending buffer: on load_i, pending <= {hex_i, blank_i, dp_i}, pending_valid <= 1. Loads while pending_valid overwrite (last wins; no per-load ack).
- Commit: at a frame boundary with pending_valid=1, display <= pending, pending_valid <= 0, and ack_o=1 in the next cycle only.
- Simultaneous load_i and commit on the same edge: the old pending commits (ack pulses); the new load is captured into pending and pending_valid stays 1 for the next frame.
- Frame boundary with pending_valid=0: display unchanged, no ack.
- Outputs registered, 1-cycle latency from internal state (p, digit, display):
  an_o <= (p < GUARD) ? 4'b1111 : ~(4'b0001 << digit)
  seg_o <= blank[digit] ? 7'h7F : decode(nibble[digit])
  dp_o <= blank[digit] ? 1 : ~dp[digit]
- Segment decode (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Frame length is 4*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-GUARD cycles per frame. Exactly one anode is low at any time outside guard windows.

Test Plan:
All scenarios use REFRESH_DIV=8, GUARD=2; cycle 0 is the first edge after reset release.
1. Reset/idle: no loads for 64 cycles -> an_o scans 1110,1101,1011,0111 (each low 6 of every 8 cycles, 1111 during guards); seg_o=7F, dp_o=1 throughout; ack_o=0.
2. Load 16'h1234, blank=0, dp=4'b0010 at cycle 5 -> no display change before the boundary edge at cycle 31; ack_o=1 at cycle 32 only. Digit0 then shows seg_o=19 ("4"), digit1=30 with dp_o=0, digit2=24, digit3=79.
3. Loads 16'hAAAA at cycle 3 and 16'hBEEF at cycle 10, same frame -> single ack; display shows F,E,E,b (0E,06,06,03) on digits 0..3; AAAA is never displayed.
4. load_i with 16'h5678 on exactly the boundary edge while 16'h1111 is pending -> 1111 displayed with ack. 5678 is committed at the following boundary with a second ack, 32 cycles later.
5. blank_i=4'b0101 with hex 16'hFFFF, dp=4'b1111 -> digits 0 and 2 show seg_o=7F, dp_o=1 while their anodes are low; digits 1 and 3 show 0E with dp_o=0.
6. Assert reset_n=0 asynchronously mid-digit with a word displayed and a second word pending -> outputs go to reset values before the next clk edge. After release, display is blank, and no ack occurs at the first boundary.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed 4-digit common-anode seven-segment driver
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [15:0] hex_i,
    input  logic [3:0]  blank_i,
    input  logic [3:0]  dp_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic        ack_o
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
    logic [PW-1:0] p;
    logic [1:0]    digit;
    logic [15:0]   disp_hex, pend_hex;
    logic [3:0]    disp_blank, disp_dp, pend_blank, pend_dp;
    logic          pend_valid, tick, commit;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    assign tick   = p == PW'(REFRESH_DIV - 1);
    assign commit = tick && digit == 2'd3 && pend_valid;
    assign nib    = disp_hex[{digit, 2'b00} +: 4];
    always_comb begin
        seg_dec = 7'h7F;
        case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end
    // A load on the commit edge lands in pending after the old word has moved to the display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p          <= '0;
            digit      <= 2'd0;
            disp_hex   <= 16'h0;
            disp_blank <= 4'hF;
            disp_dp    <= 4'h0;
            pend_hex   <= 16'h0;
            pend_blank <= 4'h0;
            pend_dp    <= 4'h0;
            pend_valid <= 1'b0;
            an_o       <= 4'hF;
            seg_o      <= 7'h7F;
            dp_o       <= 1'b1;
            ack_o      <= 1'b0;
        end else begin
            p          <= tick ? '0 : p + 1'b1;
            digit      <= tick ? digit + 2'd1 : digit;
            if (load_i) begin
                pend_hex   <= hex_i;
                pend_blank <= blank_i;
                pend_dp    <= dp_i;
            end
            pend_valid <= load_i | (pend_valid & ~commit);
            if (commit) begin
                disp_hex   <= pend_hex;
                disp_blank <= pend_blank;
                disp_dp    <= pend_dp;
            end
            ack_o <= commit;
            an_o  <= (p < PW'(GUARD)) ? 4'hF : ~(4'b0001 << digit);
            seg_o <= disp_blank[digit] ? 7'h7F : seg_dec;
            dp_o  <= disp_blank[digit] ? 1'b1 : ~disp_dp[digit];
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboarded check of scan timing, double-buffered commits and reset
module tb_seg7_scan_driver;
    localparam int RD = 8;
    localparam int GD = 2;
    logic        clk = 0, reset_n = 0, load_i = 0;
    logic [15:0] hex_i = 0;
    logic [3:0]  blank_i = 0, dp_i = 0;
    logic [6:0]  seg_o;
    logic        dp_o, ack_o;
    logic [3:0]  an_o;
    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk(clk), .reset_n(reset_n), .load_i(load_i), .hex_i(hex_i),
        .blank_i(blank_i), .dp_i(dp_i), .seg_o(seg_o), .dp_o(dp_o),
        .an_o(an_o), .ack_o(ack_o)
    );
    always #5 clk = ~clk;
    typedef struct {
        int          edge_n;
        logic [15:0] hex;
        logic [3:0]  blank;
        logic [3:0]  dp;
    } word_t;
    word_t       sb[$];
    int          total = 0, bad = 0, n = 0;
    logic [15:0] sh_hex;
    logic [3:0]  sh_blank, sh_dp;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          le [8] = '{69, 99, 106, 140, 159, 200, 230, 260};
    logic [15:0] lh [8] = '{16'h1234, 16'hAAAA, 16'hBEEF, 16'h1111, 16'h5678, 16'hFFFF, 16'hC0DE, 16'h9A5B};
    logic [3:0]  lb [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0101, 4'h0, 4'h0};
    logic [3:0]  ld [8] = '{4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'b1000, 4'h1};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    task automatic chk_rst();
        chk("rst_an", {12'h0, an_o}, 16'h000F);
        chk("rst_seg", {9'h0, seg_o}, 16'h007F);
        chk("rst_dp", {15'h0, dp_o}, 16'h0001);
        chk("rst_ack", {15'h0, ack_o}, 16'h0000);
    endtask

    // Edge n: loads become due at the next boundary edge (n%32==31), or the one after if n is itself a boundary.
    task automatic step(input logic ld_v, input logic [15:0] h, input logic [3:0] b, input logic [3:0] dv);
        word_t      w;
        int         tgt, pos;
        logic [1:0] dg;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_ack;
        load_i = ld_v; hex_i = h; blank_i = b; dp_i = dv;
        if (ld_v) begin
            tgt = (n % 32 == 31) ? n + 32 : n - n % 32 + 31;
            w = '{tgt, h, b, dv};
            if (sb.size() > 0 && sb[$].edge_n == tgt) sb[$] = w;
            else sb.push_back(w);
        end
        @(posedge clk);
        #1;
        load_i = 0;
        dg    = 2'((n / 8) % 4);
        pos   = n % 8;
        e_an  = (pos < GD) ? 4'hF : ~(4'b0001 << dg);
        e_seg = sh_blank[dg] ? 7'h7F : seg_tab[sh_hex[{dg, 2'b00} +: 4]];
        e_dp  = sh_blank[dg] ? 1'b1 : ~sh_dp[dg];
        e_ack = sb.size() > 0 && sb[0].edge_n == n;
        chk("an", {12'h0, an_o}, {12'h0, e_an});
        chk("seg", {9'h0, seg_o}, {9'h0, e_seg});
        chk("dp", {15'h0, dp_o}, {15'h0, e_dp});
        chk("ack", {15'h0, ack_o}, {15'h0, e_ack});
        if (e_ack) begin
            w = sb.pop_front();
            sh_hex = w.hex; sh_blank = w.blank; sh_dp = w.dp;
        end
        n++;
    endtask

    initial begin
        logic hit;
        int   k;
        sh_hex = 0; sh_blank = 4'hF; sh_dp = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_rst();
        reset_n = 1;
        for (int i = 0; i < 269; i++) begin
            hit = 0; k = 0;
            for (int j = 0; j < 8; j++)
                if (le[j] == n) begin hit = 1; k = j; end
            step(hit, lh[k], lb[k], ld[k]);
        end
        #2 reset_n = 0;
        #1 chk_rst();
        sb.delete();
        sh_hex = 0; sh_blank = 4'hF; sh_dp = 0;
        @(posedge clk);
        #1;
        chk_rst();
        reset_n = 1;
        n = 0;
        for (int i = 0; i < 64; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
